// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 multiply/divide with HI/LO result registers.
// MULT/MULTU/DIV/DIVU take WIDTH cycles in RUN, then one DONE cycle.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    output logic             o_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_zero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    localparam int W = WIDTH;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]   x_q, x_d;
    logic [W-1:0]     b_q, b_d;
    logic             div_q, div_d, sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
    logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;

    logic             a_neg, b_neg, accept;
    logic [W-1:0]     a_mag, b_mag, q, r, res_hi, res_lo;
    logic [W:0]       sum, trial;
    logic [2*W-1:0]   x_step, p_fix;

    // x holds {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide
    always_comb begin
        a_neg  = ~i_op[0] & i_A[W-1];
        b_neg  = ~i_op[0] & i_B[W-1];
        a_mag  = a_neg ? -i_A : i_A;
        b_mag  = b_neg ? -i_B : i_B;
        accept = i_valid & (state_q == IDLE);
        sum    = {1'b0, x_q[2*W-1:W]} + {1'b0, (x_q[0] ? b_q : {W{1'b0}})};
        trial  = {x_q[2*W-1:W], x_q[W-1]} - {1'b0, b_q};
        x_step = div_q ? (trial[W] ? {x_q[2*W-2:0], 1'b0} : {trial[W-1:0], x_q[W-2:0], 1'b1})
                       : {sum, x_q[W-1:1]};
        p_fix  = (sa_q ^ sb_q) ? -x_step : x_step;
        q      = x_step[W-1:0];
        r      = x_step[2*W-1:W];
        res_hi = div_q ? (sa_q ? -r : r) : p_fix[2*W-1:W];
        res_lo = div_q ? ((b_q == '0) ? {W{1'b1}} : ((sa_q ^ sb_q) ? -q : q)) : p_fix[W-1:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        b_d     = b_q;
        div_d   = div_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: if (accept) begin
                if (i_op == 3'b100) hi_d = i_A;
                else if (i_op == 3'b101) lo_d = i_A;
                else if (!i_op[2]) begin
                    state_d = RUN;
                    cnt_d   = CNT_W'(W - 1);
                    div_d   = i_op[1];
                    sa_d    = a_neg;
                    sb_d    = b_neg;
                    x_d     = {{W{1'b0}}, (i_op[1] ? a_mag : b_mag)};
                    b_d     = i_op[1] ? b_mag : a_mag;
                end
            end
            RUN: begin
                x_d   = x_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    dz_d    = div_q ? (b_q == '0) : dz_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            b_q     <= '0;
            div_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            b_q     <= b_d;
            div_q   <= div_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign o_ready    = (state_q == IDLE);
    assign o_busy     = (state_q != IDLE);
    assign o_done     = (state_q == DONE);
    assign o_div_zero = dz_q;
    assign o_hi       = hi_q;
    assign o_lo       = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit at WIDTH = 32.
module tb_mul_div_unit;
    logic        clk, i_reset, i_valid;
    logic [2:0]  i_op;
    logic [31:0] i_A, i_B;
    logic        o_ready, o_busy, o_done, o_div_zero;
    logic [31:0] o_hi, o_lo;
    int          tests = 0;
    int          fails = 0;

    mul_div_unit dut (
        .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_op(i_op),
        .i_A(i_A), .i_B(i_B), .o_ready(o_ready), .o_busy(o_busy),
        .o_done(o_done), .o_div_zero(o_div_zero), .o_hi(o_hi), .o_lo(o_lo)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        i_valid = 1; i_op = op; i_A = a; i_B = b;
        @(negedge clk);
        i_valid = 0; i_op = 3'b110; i_A = 32'hDEADBEEF; i_B = 32'h12345678;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!o_done && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        tests++;
        if ({o_ready, o_busy, o_done, o_div_zero} !== 4'b1000) begin
            fails++; $display("FAIL reset_flags got=%b exp=1000", {o_ready, o_busy, o_done, o_div_zero});
        end
        tests++;
        if ({o_hi, o_lo} !== 64'h0) begin
            fails++; $display("FAIL reset_hilo got=%h exp=0", {o_hi, o_lo});
        end
        i_reset = 1;
    endtask

    task automatic test_mult;
        int n;
        start(3'b000, 32'd7, 32'hFFFFFFFD);
        wait_done(n);
        tests++;
        if (n !== 32) begin fails++; $display("FAIL mult_latency got=%0d exp=32", n); end
        tests++;
        if ({o_hi, o_lo} !== 64'hFFFFFFFF_FFFFFFEB) begin
            fails++; $display("FAIL mult_result got=%h exp=ffffffffffffffeb", {o_hi, o_lo});
        end
        @(negedge clk);
        tests++;
        if ({o_done, o_ready} !== 2'b01) begin
            fails++; $display("FAIL mult_done_pulse got=%b exp=01", {o_done, o_ready});
        end
    endtask

    task automatic test_multu;
        int busy = 0;
        start(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        while (o_busy && busy < 100) begin
            busy++;
            @(negedge clk);
        end
        tests++;
        if (busy !== 33) begin fails++; $display("FAIL multu_busy got=%0d exp=33", busy); end
        tests++;
        if ({o_hi, o_lo} !== 64'hFFFFFFFE_00000001) begin
            fails++; $display("FAIL multu_result got=%h exp=fffffffe00000001", {o_hi, o_lo});
        end
    endtask

    task automatic test_div;
        int n;
        start(3'b010, 32'hFFFFFFF9, 32'd2);
        wait_done(n);
        tests++;
        if ({o_hi, o_lo} !== 64'hFFFFFFFF_FFFFFFFD) begin
            fails++; $display("FAIL div_neg7_2 got=%h exp=fffffffffffffffd", {o_hi, o_lo});
        end
        start(3'b010, 32'd7, 32'hFFFFFFFE);
        wait_done(n);
        tests++;
        if ({o_hi, o_lo} !== 64'h00000001_FFFFFFFD) begin
            fails++; $display("FAIL div_7_neg2 got=%h exp=00000001fffffffd", {o_hi, o_lo});
        end
        start(3'b010, 32'hFFFFFFF9, 32'hFFFFFFFE);
        wait_done(n);
        tests++;
        if ({o_hi, o_lo} !== 64'hFFFFFFFF_00000003) begin
            fails++; $display("FAIL div_neg7_neg2 got=%h exp=ffffffff00000003", {o_hi, o_lo});
        end
        start(3'b010, 32'h80000000, 32'hFFFFFFFF);
        wait_done(n);
        tests++;
        if ({o_div_zero, o_hi, o_lo} !== {1'b0, 64'h00000000_80000000}) begin
            fails++; $display("FAIL div_minint got=%h dz=%b exp=0000000080000000 dz=0", {o_hi, o_lo}, o_div_zero);
        end
    endtask

    task automatic test_div_zero;
        int n;
        start(3'b011, 32'd100, 32'd0);
        wait_done(n);
        tests++;
        if (n !== 32) begin fails++; $display("FAIL divz_latency got=%0d exp=32", n); end
        tests++;
        if ({o_div_zero, o_hi, o_lo} !== {1'b1, 64'h00000064_FFFFFFFF}) begin
            fails++; $display("FAIL divu_zero got=%h dz=%b exp=00000064ffffffff dz=1", {o_hi, o_lo}, o_div_zero);
        end
        start(3'b101, 32'd5, 32'd0);
        tests++;
        if ({o_lo, o_div_zero, o_done, o_ready} !== {32'd5, 3'b101}) begin
            fails++; $display("FAIL mtlo got=lo=%h dz/done/rdy=%b exp=lo=5 dz/done/rdy=101", o_lo, {o_div_zero, o_done, o_ready});
        end
        start(3'b100, 32'hA5A5A5A5, 32'd0);
        tests++;
        if ({o_hi, o_lo, o_done} !== {32'hA5A5A5A5, 32'd5, 1'b0}) begin
            fails++; $display("FAIL mthi got=hi=%h lo=%h done=%b exp=hi=a5a5a5a5 lo=5 done=0", o_hi, o_lo, o_done);
        end
        start(3'b001, 32'd2, 32'd3);
        wait_done(n);
        tests++;
        if ({o_div_zero, o_lo} !== {1'b1, 32'd6}) begin
            fails++; $display("FAIL mult_keeps_dz got=dz=%b lo=%h exp=dz=1 lo=6", o_div_zero, o_lo);
        end
        start(3'b010, 32'hFFFFFFF8, 32'd0);
        wait_done(n);
        tests++;
        if ({o_div_zero, o_hi, o_lo} !== {1'b1, 64'hFFFFFFF8_FFFFFFFF}) begin
            fails++; $display("FAIL div_zero_signed got=%h dz=%b exp=fffffff8ffffffff dz=1", {o_hi, o_lo}, o_div_zero);
        end
        start(3'b011, 32'd10, 32'd3);
        wait_done(n);
        tests++;
        if ({o_div_zero, o_hi, o_lo} !== {1'b0, 64'h00000001_00000003}) begin
            fails++; $display("FAIL divu_clears_dz got=%h dz=%b exp=0000000100000003 dz=0", {o_hi, o_lo}, o_div_zero);
        end
        @(negedge clk);
        i_valid = 1; i_op = 3'b110; i_A = 32'h1; i_B = 32'h1;
        @(negedge clk);
        i_valid = 0;
        tests++;
        if ({o_ready, o_busy, o_done, o_hi, o_lo} !== {3'b100, 64'h00000001_00000003}) begin
            fails++; $display("FAIL reserved_op got=%b %h exp=100 0000000100000003", {o_ready, o_busy, o_done}, {o_hi, o_lo});
        end
    endtask

    task automatic test_busy_ignore;
        int dones = 0;
        int n;
        logic [63:0] res = 64'h0;
        logic [31:0] hi_before = o_hi;
        @(negedge clk);
        i_valid = 1; i_op = 3'b000; i_A = 32'd5; i_B = 32'hFFFFFFFA;
        @(negedge clk);
        i_op = 3'b011; i_A = 32'd1000; i_B = 32'd7;
        for (int i = 1; i <= 33; i++) begin
            @(negedge clk);
            if (i == 16) begin
                tests++;
                if (o_hi !== hi_before) begin
                    fails++; $display("FAIL hi_stable_in_run got=%h exp=%h", o_hi, hi_before);
                end
            end
            if (o_done) begin dones++; res = {o_hi, o_lo}; end
        end
        tests++;
        if (dones !== 1 || res !== 64'hFFFFFFFF_FFFFFFE2) begin
            fails++; $display("FAIL busy_ignore got=dones=%0d res=%h exp=dones=1 res=ffffffffffffffe2", dones, res);
        end
        tests++;
        if (o_ready !== 1'b1) begin fails++; $display("FAIL ready_edge33 got=%b exp=1", o_ready); end
        @(negedge clk);
        i_valid = 0;
        tests++;
        if (o_busy !== 1'b1) begin fails++; $display("FAIL accept_edge34 got=%b exp=1", o_busy); end
        wait_done(n);
        tests++;
        if ({o_hi, o_lo} !== {32'd6, 32'd142}) begin
            fails++; $display("FAIL divu_after_busy got=%h exp=000000060000008e", {o_hi, o_lo});
        end
    endtask

    task automatic test_reset_abort;
        int dones = 0;
        int n;
        start(3'b011, 32'd9, 32'd2);
        repeat (9) @(negedge clk);
        i_reset = 0;
        #1;
        tests++;
        if ({o_ready, o_busy, o_done, o_div_zero, o_hi, o_lo} !== {4'b1000, 64'h0}) begin
            fails++; $display("FAIL reset_abort got=%b %h exp=1000 0", {o_ready, o_busy, o_done, o_div_zero}, {o_hi, o_lo});
        end
        @(negedge clk);
        i_reset = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_done || o_lo !== 32'h0) dones++;
        end
        tests++;
        if (dones !== 0) begin fails++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
        start(3'b001, 32'd3, 32'd4);
        wait_done(n);
        tests++;
        if ({o_hi, o_lo} !== 64'h00000000_0000000C) begin
            fails++; $display("FAIL multu_after_reset got=%h exp=000000000000000c", {o_hi, o_lo});
        end
    endtask

    initial begin
        i_reset = 1; i_valid = 0; i_op = 3'b000; i_A = 32'h0; i_B = 32'h0;
        #1 i_reset = 0;
        test_reset;
        test_mult;
        test_multu;
        test_div;
        test_div_zero;
        test_busy_ignore;
        test_reset_abort;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; the block SHALL support any even WIDTH >= 4.
REQ-002 Parameter CNT_W, default $clog2(WIDTH), iteration counter width.
REQ-003 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 i_reset  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 i_valid  input  1  operation request, sampled on the rising edge.
REQ-006 i_op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
REQ-007 i_A  input  WIDTH  first operand (multiplicand / dividend / MTHI-MTLO source).
REQ-008 i_B  input  WIDTH  second operand (multiplier / divisor).
REQ-009 o_ready  output  1  high when a request will be accepted (state IDLE).
REQ-010 o_busy  output  1  high in RUN and DONE.
REQ-011 o_done  output  1  one-cycle pulse; HI/LO hold the new MULT/DIV result.
REQ-012 o_div_zero  output  1  sticky flag: last completed DIV/DIVU had divisor 0.
REQ-013 o_hi  output  WIDTH  HI register (upper product / remainder).
REQ-014 o_lo  output  WIDTH  LO register (lower product / quotient).

Function
REQ-015 Three-state FSM SHALL be used: IDLE, RUN, DONE.
REQ-016 Accept = i_valid & o_ready at a rising edge; requests while o_busy SHALL be ignored, not queued.
REQ-017 MTHI/MTLO accepted: HI (resp. LO) <= i_A at that edge; FSM stays IDLE; no o_done; o_div_zero unchanged.
REQ-018 Reserved i_op accepted: no state change, no o_done.
REQ-019 MULT/MULTU/DIV/DIVU accepted: operands latched, counter <= WIDTH-1, IDLE -> RUN.
REQ-020 RUN: one radix-2 iteration per cycle (shift-add multiply, restoring divide); counter decrements; at the edge where counter == 0 the FSM SHALL go RUN -> DONE and write HI/LO.
REQ-021 Latency: accept at edge 0 -> HI/LO updated at edge WIDTH -> o_done high for cycle WIDTH..WIDTH+1 -> IDLE after edge WIDTH+1; earliest next accept is edge WIDTH+2.
REQ-022 DONE -> IDLE unconditionally after one cycle.
REQ-023 HI/LO SHALL NOT change during RUN; intermediate state is kept in internal registers only.
REQ-024 MULTU: {HI,LO} = unsigned i_A * i_B, full 2*WIDTH bits, no truncation.
REQ-025 MULT: {HI,LO} = signed two's-complement product, 2*WIDTH bits; computed on magnitudes with sign fixed at completion.
REQ-026 DIVU: LO = i_A / i_B, HI = i_A % i_B, unsigned.
REQ-027 DIV: quotient truncates toward zero; remainder takes dividend sign; |remainder| < |divisor|.
REQ-028 DIV of most-negative value by -1: LO = most-negative value, HI = 0, no flag.
REQ-029 Divisor 0 (DIV or DIVU): full latency still applies; LO = all ones, HI = i_A; o_div_zero <= 1 at the completion edge.
REQ-030 o_div_zero is cleared at completion of any DIV/DIVU with nonzero divisor; MULT/MULTU/MTHI/MTLO leave it unchanged.
REQ-031 Operand changes on i_A/i_B/i_op after acceptance SHALL NOT affect the running operation.

Reset
REQ-032 i_reset low SHALL immediately (asynchronously) force: FSM IDLE, counter 0, o_hi 0, o_lo 0, o_done 0, o_div_zero 0, o_busy 0, o_ready 1.
REQ-033 Reset during RUN or DONE SHALL abort the operation; no partial result reaches HI/LO and no o_done is produced.
REQ-034 First accept is possible at the first rising edge with i_reset high.

Verification (WIDTH = 32)
REQ-035 MULT i_A=7, i_B=0xFFFFFFFD (-3) -> after 32 cycles o_done pulses once; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-036 MULTU i_A=i_B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; o_busy high for exactly 33 cycles.
REQ-037 DIV i_A=0xFFFFFFF9 (-7), i_B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, o_div_zero=0.
REQ-038 DIVU i_A=100, i_B=0 -> LO=0xFFFFFFFF, HI=0x00000064, o_div_zero=1; then MTLO i_A=5 -> LO=5, o_div_zero stays 1, no o_done.
REQ-039 Accept MULT, assert i_valid with new DIVU in cycles 1..33 -> all ignored, result matches MULT only; request at edge 34 accepted.
REQ-040 Start DIVU 9/2, pull i_reset low at cycle 10 -> outputs at reset values immediately; release, no o_done; subsequent MULTU 3*4 -> LO=12, HI=0.
